sr_ff_sequencer: RTL

Synthesizable stimulus-and-check engine for the SR flip-flop interface: it is the driving end of the `s`/`r`/`reset` pins and the observing end of `q`/`q_bar`. On `start` it resets the attached flip-flop, plays a fixed 8-step S/R sequence against it, compares every response with an internal reference model, and reports a pass/fail verdict with an error count. It is used for on-chip self-test of SR storage cells and as a reusable bench component.

---
 rtl/sr_ff_sequencer_if.sv | 26 ++
 rtl/sr_ff_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sr_ff_sequencer_if.sv
// Pin bundle between the SR flip-flop self-test sequencer and the cell it exercises.
// The sequencer takes the master view; the attached cell or its harness takes the slave view.
interface sr_ff_sequencer_if;
   logic       start;
   logic       s;
   logic       r;
   logic       dut_reset;
   logic       q;
   logic       q_bar;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic       first_err_valid;
   logic [2:0] first_err_step;

   modport master (
      input  start, q, q_bar,
      output s, r, dut_reset, busy, done, pass, err_count, first_err_valid, first_err_step
   );

   modport slave (
      output start, q, q_bar,
      input  s, r, dut_reset, busy, done, pass, err_count, first_err_valid, first_err_step
   );
endinterface

// File: rtl/sr_ff_sequencer.sv
// Self-test engine for an SR storage cell: resets it, plays an 8-step S/R pattern,
// checks q/q_bar against the expected state after each step and reports a verdict.
module sr_ff_sequencer #(
   parameter int HOLD_CYCLES = 1
) (
   input logic                clk,
   input logic                reset,
   sr_ff_sequencer_if.master  bus
);

   typedef enum logic [2:0] {IDLE, INIT, DRIVE, CHECK, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [2:0] r_step, w_step_nxt;
   logic       r_s, w_s_nxt;
   logic       r_r, w_r_nxt;
   logic       r_dut_reset, w_dut_reset_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_done, w_done_nxt;
   logic       r_pass, w_pass_nxt;
   logic [7:0] r_err, w_err_nxt;
   logic       r_fev, w_fev_nxt;
   logic [2:0] r_fes, w_fes_nxt;
   logic [1:0] w_sr_cur, w_sr_next;
   logic       w_fail;

   // Step ROM: {s, r} to drive, and the q the cell must hold afterwards
   function automatic logic [1:0] rom_sr(input logic [2:0] idx);
      case (idx)
         3'd0:    return 2'b10;
         3'd2:    return 2'b01;
         3'd4:    return 2'b11;
         3'd6:    return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic rom_q(input logic [2:0] idx);
      return (idx == 3'd0) || (idx == 3'd1);
   endfunction

   // Steps 4/5 exercise the forbidden S=R=1 input, whose result is undefined
   function automatic logic step_masked(input logic [2:0] idx);
      return (idx == 3'd4) || (idx == 3'd5);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_sr_cur  = rom_sr(r_step);
   assign w_sr_next = rom_sr(r_step + 3'd1);
   assign w_fail    = !step_masked(r_step) &&
                      ((bus.q != rom_q(r_step)) || (bus.q_bar != ~bus.q));

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_step_nxt      = r_step;
      w_s_nxt         = r_s;
      w_r_nxt         = r_r;
      w_dut_reset_nxt = r_dut_reset;
      w_busy_nxt      = r_busy;
      w_done_nxt      = r_done;
      w_pass_nxt      = r_pass;
      w_err_nxt       = r_err;
      w_fev_nxt       = r_fev;
      w_fes_nxt       = r_fes;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_state_nxt     = INIT;
               w_cnt_nxt       = 4'd0;
               w_step_nxt      = 3'd0;
               w_s_nxt         = 1'b0;
               w_r_nxt         = 1'b0;
               w_dut_reset_nxt = 1'b1;
               w_busy_nxt      = 1'b1;
               w_done_nxt      = 1'b0;
               w_pass_nxt      = 1'b0;
               w_err_nxt       = 8'd0;
               w_fev_nxt       = 1'b0;
               w_fes_nxt       = 3'd0;
            end
         end
         INIT: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt     = DRIVE;
               w_cnt_nxt       = 4'd0;
               w_dut_reset_nxt = 1'b0;
               {w_s_nxt, w_r_nxt} = w_sr_cur;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         DRIVE: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = CHECK;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         CHECK: begin
            if (w_fail) begin
               w_err_nxt = sat_inc(r_err);
               if (!r_fev) begin
                  w_fev_nxt = 1'b1;
                  w_fes_nxt = r_step;
               end
            end
            if (r_step == 3'd7) begin
               w_state_nxt = DONE;
               w_s_nxt     = 1'b0;
               w_r_nxt     = 1'b0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_pass_nxt  = (w_err_nxt == 8'd0);
            end else begin
               w_state_nxt = DRIVE;
               w_step_nxt  = r_step + 3'd1;
               {w_s_nxt, w_r_nxt} = w_sr_next;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_step      <= 3'd0;
         r_s         <= 1'b0;
         r_r         <= 1'b0;
         r_dut_reset <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err       <= 8'd0;
         r_fev       <= 1'b0;
         r_fes       <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_step      <= w_step_nxt;
         r_s         <= w_s_nxt;
         r_r         <= w_r_nxt;
         r_dut_reset <= w_dut_reset_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_pass      <= w_pass_nxt;
         r_err       <= w_err_nxt;
         r_fev       <= w_fev_nxt;
         r_fes       <= w_fes_nxt;
      end
   end

   assign bus.s               = r_s;
   assign bus.r               = r_r;
   assign bus.dut_reset       = r_dut_reset;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.pass            = r_pass;
   assign bus.err_count       = r_err;
   assign bus.first_err_valid = r_fev;
   assign bus.first_err_step  = r_fes;

endmodule
